// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage redirect controller: arbitrates restart/trap/branch redirects toward the PC
// register, parks a redirect while instruction memory is busy, and sequences boot and drain holds.
module fetch_redirect_ctrl #(
    parameter int BOOT_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_req,
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              hazard_stall,
    input  logic              imem_busy,
    output logic              pc_stall_n,
    output logic              pc_flush,
    output logic              pc_jump,
    output logic [ADDR_W-1:0] pc_jump_addr,
    output logic              misalign_err,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush
);

    localparam int CNT_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BOOT_LOAD  = CNT_W'(BOOT_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_PEND,
        ST_DRAIN
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] pend_addr_reg, pend_addr_next;
    logic              pend_trap_reg, pend_trap_next;
    logic [ADDR_W-1:0] raw_target;
    logic              issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_BOOT;
            cnt_reg       <= BOOT_LOAD;
            pend_addr_reg <= '0;
            pend_trap_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_addr_reg <= pend_addr_next;
            pend_trap_reg <= pend_trap_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_addr_next = pend_addr_reg;
        pend_trap_next = pend_trap_reg;
        pc_stall_n     = 1'b0;
        pc_flush       = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        issue          = 1'b0;
        raw_target     = '0;

        case (state_reg)
            ST_BOOT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            ST_RUN: begin
                pc_stall_n = !(hazard_stall || imem_busy);
                if (flush_req) begin
                    pc_flush     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    cnt_next     = DRAIN_LOAD;
                    state_next   = ST_DRAIN;
                end else if (trap_valid || br_valid) begin
                    raw_target   = trap_valid ? trap_addr : br_addr;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = trap_valid;
                    if (imem_busy) begin
                        pend_addr_next = raw_target;
                        pend_trap_next = trap_valid;
                        state_next     = ST_PEND;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end

            ST_PEND: begin
                if_id_flush = 1'b1;
                if (flush_req) begin
                    pc_flush       = 1'b1;
                    id_ex_flush    = 1'b1;
                    ex_mem_flush   = 1'b1;
                    pend_addr_next = '0;
                    pend_trap_next = 1'b0;
                    cnt_next       = DRAIN_LOAD;
                    state_next     = ST_DRAIN;
                end else begin
                    // A late trap replaces whatever is parked and is issued directly if memory frees up now.
                    raw_target = trap_valid ? trap_addr : pend_addr_reg;
                    if (trap_valid) begin
                        id_ex_flush    = 1'b1;
                        ex_mem_flush   = 1'b1;
                        pend_addr_next = trap_addr;
                        pend_trap_next = 1'b1;
                    end
                    if (!imem_busy) begin
                        issue          = 1'b1;
                        pend_trap_next = 1'b0;
                        state_next     = ST_RUN;
                    end
                end
            end

            ST_DRAIN: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                if (flush_req) begin
                    pc_flush = 1'b1;
                    cnt_next = DRAIN_LOAD;
                end else if (cnt_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            default: begin
                state_next = ST_BOOT;
                cnt_next   = BOOT_LOAD;
            end
        endcase
    end

    assign pc_jump      = issue;
    assign pc_jump_addr = issue ? {raw_target[ADDR_W-1:2], 2'b00} : '0;
    assign misalign_err = issue && (raw_target[1:0] != 2'b00);

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Fetch-stage controller that drives the program-counter register's `stall_n`, `flush`, `jump` and `jump_addr` inputs and the front-end pipeline-kill signals. It arbitrates redirect sources (pipeline restart, trap, branch) and holds a redirect while instruction memory is busy. It also sequences a post-reset boot hold and a post-restart drain period. It sits between the hazard and EX/trap logic and the PC register.

## Interface
- `BOOT_CYCLES`, default 4: cycles the PC is held after reset release.
- `DRAIN_CYCLES`, default 3: bubble cycles after a restart.
- `ADDR_W`, default 32: address width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_req`  in  1  full pipeline restart request; PC returns to 0.
- `trap_valid`  in  1  trap redirect request.
- `trap_addr`  in  ADDR_W  trap target.
- `br_valid`  in  1  taken branch or jump redirect request from EX.
- `br_addr`  in  ADDR_W  branch target.
- `hazard_stall`  in  1  load-use stall from ID.
- `imem_busy`  in  1  instruction memory cannot accept a new fetch address.
- `pc_stall_n`  out  1  to the PC register: 1 = advance.
- `pc_flush`  out  1  to the PC register: force PC to 0.
- `pc_jump`  out  1  to the PC register: load `pc_jump_addr`.
- `pc_jump_addr`  out  ADDR_W  redirect target, with bits [1:0] forced to 0.
- `misalign_err`  out  1  one-cycle pulse when an issued target had a nonzero [1:0].
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  pipeline-register kills.

## Operation
- States: BOOT, RUN, PEND, DRAIN. On reset the state is BOOT and the down-counter `cnt` is loaded with BOOT_CYCLES.
- Reset values: all outputs are 0; `pend_addr` = 0; `pend_trap` = 0.
- Priority: `flush_req` > `trap_valid` > `br_valid`. `pc_flush` and `pc_jump` are never both 1.
- Default outputs are 0, except `pc_stall_n` = !(hazard_stall | imem_busy) in RUN.
- BOOT: `pc_stall_n` = 0. `cnt` decrements every cycle and the state moves to RUN when `cnt` = 0. With BOOT_CYCLES = 0 the state moves to RUN on the first edge. All requests are ignored.
- RUN behaviour:
  - On `flush_req`: `pc_flush` = 1 and all three kills = 1. Next state is DRAIN with `cnt` = DRAIN_CYCLES.
  - On a redirect with `imem_busy` = 0: `pc_jump` = 1 and `pc_jump_addr` = the selected target. `if_id_flush` = `id_ex_flush` = 1, and `ex_mem_flush` = 1 for a trap only. State stays RUN.
  - On a redirect with `imem_busy` = 1: the target goes into `pend_addr` and the type into `pend_trap`. The same kills are issued this cycle and `pc_jump` = 0. Next state is PEND.
- PEND behaviour:
  - `pc_stall_n` = 0 and `if_id_flush` = 1 every cycle.
  - A new `trap_valid` overwrites a pending branch and issues `id_ex_flush` and `ex_mem_flush` that cycle.
  - `br_valid` is ignored.
  - On the first cycle with `imem_busy` = 0: `pc_jump` = 1 with `pend_addr`, or with `trap_addr` if a trap arrives that same cycle. Next state is RUN.
  - `flush_req` discards the pending redirect and acts exactly as in RUN.
- DRAIN: `pc_stall_n` = 0 and all kills = 1 every cycle. `cnt` decrements and the state moves to RUN when `cnt` = 0. A `flush_req` reloads `cnt` and pulses `pc_flush` again. Trap and branch requests are ignored.
- `misalign_err` is 1 in the same cycle as a `pc_jump` whose raw target had [1:0] ≠ 0. The target is still issued, aligned.

## Timing
- All outputs are combinational from state and inputs. State, `cnt`, `pend_addr` and `pend_trap` update on the rising edge of `clk`.
- Redirect latency: when the memory is idle, `pc_jump` is asserted in the request cycle, so the PC holds the target on the next edge.
- Pending redirect: `pc_jump` is asserted in the first cycle with `imem_busy` = 0.
- BOOT lasts BOOT_CYCLES + 1 cycles after `rst_n` rises. The first `pc_stall_n` = 1 occurs in the cycle after `cnt` reaches 0.
- DRAIN gives DRAIN_CYCLES + 1 stalled cycles after the `pc_flush` cycle.
- Asserting `rst_n` = 0 at any point immediately zeroes all outputs and the pending state, and re-enters BOOT.

## Test plan
- Reset release with BOOT_CYCLES = 4 -> `pc_stall_n` = 0 for 5 cycles, then 1. All other outputs stay 0 throughout.
- RUN, `br_valid` = 1 with `br_addr` = 0x100 and `imem_busy` = 0 -> same cycle: `pc_jump` = 1, `pc_jump_addr` = 0x100, `if_id_flush` = `id_ex_flush` = 1, `ex_mem_flush` = 0.
- `br_valid` with target 0x200 while `imem_busy` = 1 for 3 cycles, then a trap to 0x80 in cycle 2 -> PEND; `pc_jump` = 1 with 0x80 in cycle 4; `ex_mem_flush` = 1 in cycle 2.
- Same cycle `flush_req` = 1, `trap_valid` = 1, `br_valid` = 1 -> `pc_flush` = 1, `pc_jump` = 0, all kills = 1. DRAIN lasts 4 cycles and a branch during DRAIN is ignored.
- Branch to 0x102 -> `pc_jump_addr` = 0x100 and `misalign_err` = 1 for 1 cycle.
- `rst_n` = 0 during PEND -> all outputs 0 at once; after release the state is BOOT and no stale `pc_jump` appears.
